drp_responder: RTL and testbench

- DRP slave/responder: the transceiver-side end of the DRP handshake our DRP read master drives.
- Accepts a one-cycle drp_en strobe with drp_we, drp_addr and drp_di, and services it against a 256x16 register bank.
- Returns a one-cycle drp_rdy with drp_do after a fixed latency.
- Used to emulate transceiver config space in simulation and as an on-chip status/config register file behind DRP; a local port lets fabric logic update registers.

---
 rtl/drp_pkg.sv | 22 ++
 rtl/drp_responder_if.sv | 22 ++
 rtl/drp_reg_bank.sv | 49 ++++
 rtl/drp_responder.sv | 150 +++++++++++++++
 tb/tb_drp_responder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/drp_pkg.sv
// Shared widths, FSM encoding and address helpers for the DRP responder slice.
package drp_pkg;

    localparam int DRP_ADDR_W = 10;
    localparam int DRP_DATA_W = 16;
    localparam int BANK_AW    = 8;
    localparam int BANK_DEPTH = 256;

    // Read data returned for addresses outside the bank.
    localparam logic [DRP_DATA_W-1:0] OOR_RDATA = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } drp_state_e;

    function automatic logic addr_in_range(input logic [DRP_ADDR_W-1:0] addr);
        return (addr[DRP_ADDR_W-1:BANK_AW] == '0);
    endfunction

endpackage

// File: rtl/drp_responder_if.sv
// DRP handshake bundle between a DRP master and the responder.
interface drp_responder_if;
    import drp_pkg::*;

    logic                  drp_en;
    logic                  drp_we;
    logic [DRP_ADDR_W-1:0] drp_addr;
    logic [DRP_DATA_W-1:0] drp_di;
    logic                  drp_rdy;
    logic [DRP_DATA_W-1:0] drp_do;

    modport master (
        output drp_en, drp_we, drp_addr, drp_di,
        input  drp_rdy, drp_do
    );

    modport slave (
        input  drp_en, drp_we, drp_addr, drp_di,
        output drp_rdy, drp_do
    );

endinterface

// File: rtl/drp_reg_bank.sv
// 256x16 register bank: DRP and local write ports (DRP wins on the same address),
// combinational DRP read and a registered local read.
module drp_reg_bank
    import drp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_drp_we,
    input  logic [BANK_AW-1:0]    i_drp_addr,
    input  logic [DRP_DATA_W-1:0] i_drp_wdata,
    output logic [DRP_DATA_W-1:0] o_drp_rdata,
    input  logic                  i_lb_we,
    input  logic [BANK_AW-1:0]    i_lb_addr,
    input  logic [DRP_DATA_W-1:0] i_lb_wdata,
    output logic [DRP_DATA_W-1:0] o_lb_rdata
);

    logic [DRP_DATA_W-1:0] r_mem [BANK_DEPTH];
    logic [DRP_DATA_W-1:0] r_lb_rdata;

    // Storage: the DRP write is issued last so it overrides a same-address local write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BANK_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_lb_we) begin
                r_mem[i_lb_addr] <= i_lb_wdata;
            end
            if (i_drp_we) begin
                r_mem[i_drp_addr] <= i_drp_wdata;
            end
        end
    end

    // Local read port, one cycle behind the address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lb_rdata <= '0;
        end else begin
            r_lb_rdata <= r_mem[i_lb_addr];
        end
    end

    assign o_drp_rdata = r_mem[i_drp_addr];
    assign o_lb_rdata  = r_lb_rdata;

endmodule

// File: rtl/drp_responder.sv
// DRP responder: fixed-latency FSM in front of a 256x16 register bank.
// Optional build macro DRP_WR_MASK_EN makes addresses >= RO_BASE DRP-read-only.
module drp_responder
    import drp_pkg::*;
#(
    parameter int         RDY_LATENCY = 3,
    parameter logic [7:0] RO_BASE     = 8'hC0
) (
    input  logic                  clk,
    input  logic                  rst,
    drp_responder_if.slave        drp,
    input  logic                  i_lb_we,
    input  logic [BANK_AW-1:0]    i_lb_addr,
    input  logic [DRP_DATA_W-1:0] i_lb_wdata,
    output logic [DRP_DATA_W-1:0] o_lb_rdata,
    output logic                  o_busy,
    output logic                  o_addr_err,
    output logic                  o_prot_err
);

`ifdef DRP_WR_MASK_EN
    localparam logic WR_MASK = 1'b1;
`else
    localparam logic WR_MASK = 1'b0;
`endif

    localparam logic [4:0] LAT_M1 = 5'(RDY_LATENCY - 1);

    drp_state_e            r_state;
    drp_state_e            w_state_nxt;
    logic [4:0]            r_cnt;
    logic [4:0]            w_cnt_nxt;
    logic                  w_latch;

    logic                  r_we;
    logic [DRP_ADDR_W-1:0] r_addr;
    logic [DRP_DATA_W-1:0] r_di;

    logic                  r_rdy;
    logic [DRP_DATA_W-1:0] r_do;
    logic                  r_busy;
    logic                  r_addr_err;
    logic                  r_prot_err;

    logic                  w_in_range;
    logic                  w_ro_hit;
    logic                  w_resp;
    logic                  w_bank_we;
    logic [DRP_DATA_W-1:0] w_bank_rdata;

    assign w_in_range = addr_in_range(r_addr);
    assign w_ro_hit   = WR_MASK & (r_addr[BANK_AW-1:0] >= RO_BASE);
    assign w_resp     = (r_state == ST_RESP);
    // The bank is written on the edge that leaves RESP, the same edge drp_rdy rises.
    assign w_bank_we  = w_resp & r_we & w_in_range & ~w_ro_hit;

    drp_reg_bank u_bank (
        .clk         (clk),
        .rst         (rst),
        .i_drp_we    (w_bank_we),
        .i_drp_addr  (r_addr[BANK_AW-1:0]),
        .i_drp_wdata (r_di),
        .o_drp_rdata (w_bank_rdata),
        .i_lb_we     (i_lb_we),
        .i_lb_addr   (i_lb_addr),
        .i_lb_wdata  (i_lb_wdata),
        .o_lb_rdata  (o_lb_rdata)
    );

    // Next-state and latency-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (drp.drp_en) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = LAT_M1;
                    w_state_nxt = (RDY_LATENCY == 1) ? ST_RESP : ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt <= 5'd1) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 5'd1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 5'd0;
            end
        endcase
    end

    // State, counter and request capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_di    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_we   <= drp.drp_we;
                r_addr <= drp.drp_addr;
                r_di   <= drp.drp_di;
            end
        end
    end

    // Registered response and status outputs; prot_err is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy      <= 1'b0;
            r_do       <= '0;
            r_busy     <= 1'b0;
            r_addr_err <= 1'b0;
            r_prot_err <= 1'b0;
        end else begin
            r_rdy      <= w_resp;
            r_addr_err <= w_resp & ~w_in_range;
            r_busy     <= (w_state_nxt != ST_IDLE);
            if (w_resp && !r_we) begin
                r_do <= w_in_range ? w_bank_rdata : OOR_RDATA;
            end else begin
                r_do <= '0;
            end
            if (drp.drp_en && (r_state != ST_IDLE)) begin
                r_prot_err <= 1'b1;
            end
        end
    end

    assign drp.drp_rdy = r_rdy;
    assign drp.drp_do  = r_do;
    assign o_busy      = r_busy;
    assign o_addr_err  = r_addr_err;
    assign o_prot_err  = r_prot_err;

endmodule

// File: tb/tb_drp_responder.sv
// Directed bench for drp_responder: vector table plus hand-written corner sequences.
module tb_drp_responder;
    import drp_pkg::*;

    localparam int LAT = 3;
`ifdef DRP_WR_MASK_EN
    localparam bit MASKED = 1'b1;
`else
    localparam bit MASKED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lb_we = 1'b0;
    logic [7:0]  lb_addr = 8'h00;
    logic [15:0] lb_wdata = 16'h0000;
    logic [15:0] lb_rdata;
    logic        busy;
    logic        addr_err;
    logic        prot_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    drp_responder_if bus ();

    drp_responder #(.RDY_LATENCY(LAT), .RO_BASE(8'hC0)) dut (
        .clk        (clk),
        .rst        (rst),
        .drp        (bus.slave),
        .i_lb_we    (lb_we),
        .i_lb_addr  (lb_addr),
        .i_lb_wdata (lb_wdata),
        .o_lb_rdata (lb_rdata),
        .o_busy     (busy),
        .o_addr_err (addr_err),
        .o_prot_err (prot_err)
    );

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [15:0] di;
        logic [15:0] exp_do;
        logic        exp_aerr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One DRP transaction; optionally a local write lands on the same edge as the response.
    task automatic drp_xact(input logic we, input logic [9:0] addr, input logic [15:0] di,
                            input logic lb_en, input logic [7:0] lb_a, input logic [15:0] lb_d,
                            output logic [15:0] rdata, output logic aerr,
                            output int lat, output int busy_cnt);
        bit got;
        got = 1'b0; lat = 0; busy_cnt = 0; rdata = 16'h0000; aerr = 1'b0;
        bus.drp_en = 1'b1; bus.drp_we = we; bus.drp_addr = addr; bus.drp_di = di;
        tick();
        bus.drp_en = 1'b0;
        while (!got && lat < 40) begin
            if (busy) busy_cnt++;
            if (lb_en && lat == LAT - 1) begin
                lb_we = 1'b1; lb_addr = lb_a; lb_wdata = lb_d;
            end
            tick();
            lat++;
            lb_we = 1'b0;
            if (bus.drp_rdy) begin
                got = 1'b1; rdata = bus.drp_do; aerr = addr_err;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rd;
        logic        ae;
        int          lat, bc, rdy_n, rdy_at;

        bus.drp_en = 1'b0; bus.drp_we = 1'b0; bus.drp_addr = 10'h000; bus.drp_di = 16'h0000;

        #2 rst = 1'b1;
        #1;
        chk("reset rdy", 32'(bus.drp_rdy), 32'd0);
        chk("reset do", 32'(bus.drp_do), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset prot_err", 32'(prot_err), 32'd0);
        chk("reset lb_rdata", 32'(lb_rdata), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        vecs.push_back('{1'b1, 10'h012, 16'hA5A5, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 10'h012, 16'h0000, 16'hA5A5, 1'b0});
        vecs.push_back('{1'b1, 10'h300, 16'h1234, 16'h0000, 1'b1});
        vecs.push_back('{1'b0, 10'h300, 16'h0000, 16'h0000, 1'b1});
        vecs.push_back('{1'b0, 10'h000, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{1'b1, 10'h0FF, 16'hBEEF, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 10'h0FF, 16'h0000, 16'hBEEF, 1'b0});
        vecs.push_back('{1'b1, 10'h1FF, 16'hDEAD, 16'h0000, 1'b1});
        vecs.push_back('{1'b0, 10'h0FF, 16'h0000, 16'hBEEF, 1'b0});
        vecs.push_back('{1'b0, 10'h0C5, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{1'b1, 10'h0C5, 16'hCAFE, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 10'h0C5, 16'h0000, MASKED ? 16'h0000 : 16'hCAFE, 1'b0});
        vecs.push_back('{1'b1, 10'h0BF, 16'h1111, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 10'h0BF, 16'h0000, 16'h1111, 1'b0});
        vecs.push_back('{1'b1, 10'h0C0, 16'h2222, 16'h0000, 1'b0});
        vecs.push_back('{1'b0, 10'h0C0, 16'h0000, MASKED ? 16'h0000 : 16'h2222, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            drp_xact(vecs[i].we, vecs[i].addr, vecs[i].di, 1'b0, 8'h00, 16'h0000, rd, ae, lat, bc);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(LAT));
            chk($sformatf("vec%0d busy_cycles", i), 32'(bc), 32'(LAT));
            chk($sformatf("vec%0d do", i), 32'(rd), 32'(vecs[i].exp_do));
            chk($sformatf("vec%0d addr_err", i), 32'(ae), 32'(vecs[i].exp_aerr));
            chk($sformatf("vec%0d busy_at_rdy", i), 32'(busy), 32'd0);
            tick();
            chk($sformatf("vec%0d rdy_pulse", i), 32'(bus.drp_rdy), 32'd0);
            chk($sformatf("vec%0d do_idle", i), 32'(bus.drp_do), 32'd0);
            chk($sformatf("vec%0d aerr_pulse", i), 32'(addr_err), 32'd0);
        end
        chk("prot_err clear", 32'(prot_err), 32'd0);

        // Second request one cycle into the first: ignored, flagged, first completes intact.
        bus.drp_en = 1'b1; bus.drp_we = 1'b0; bus.drp_addr = 10'h012; bus.drp_di = 16'h0000;
        tick();
        bus.drp_en = 1'b1; bus.drp_we = 1'b1; bus.drp_addr = 10'h012; bus.drp_di = 16'hFFFF;
        tick();
        bus.drp_en = 1'b0;
        chk("prot_err set", 32'(prot_err), 32'd1);
        rdy_n = 0; rdy_at = -1; rd = 16'h0000;
        for (int c = 2; c <= 11; c++) begin
            tick();
            if (bus.drp_rdy) begin
                rdy_n++;
                if (rdy_at < 0) begin
                    rdy_at = c; rd = bus.drp_do;
                end
            end
        end
        chk("prot rdy_count", 32'(rdy_n), 32'd1);
        chk("prot latency", 32'(rdy_at), 32'(LAT));
        chk("prot do", 32'(rd), 32'h0000A5A5);
        drp_xact(1'b0, 10'h012, 16'h0000, 1'b0, 8'h00, 16'h0000, rd, ae, lat, bc);
        chk("prot ignored_write", 32'(rd), 32'h0000A5A5);
        chk("prot_err sticky", 32'(prot_err), 32'd1);

        // Same-address collision: DRP write wins.
        drp_xact(1'b1, 10'h020, 16'h1111, 1'b1, 8'h20, 16'h2222, rd, ae, lat, bc);
        chk("coll latency", 32'(lat), 32'(LAT));
        tick();
        chk("coll lb_rdata", 32'(lb_rdata), 32'h00001111);
        // Different addresses: both commit.
        drp_xact(1'b1, 10'h021, 16'h3333, 1'b1, 8'h22, 16'h4444, rd, ae, lat, bc);
        lb_addr = 8'h21;
        tick();
        chk("diff drp_write", 32'(lb_rdata), 32'h00003333);
        lb_addr = 8'h22;
        tick();
        chk("diff lb_write", 32'(lb_rdata), 32'h00004444);
        // DRP read concurrent with a local write returns the old value.
        drp_xact(1'b0, 10'h020, 16'h0000, 1'b1, 8'h20, 16'h5555, rd, ae, lat, bc);
        chk("rbw do", 32'(rd), 32'h00001111);
        tick();
        chk("rbw lb_rdata", 32'(lb_rdata), 32'h00005555);
        drp_xact(1'b0, 10'h020, 16'h0000, 1'b0, 8'h00, 16'h0000, rd, ae, lat, bc);
        chk("rbw readback", 32'(rd), 32'h00005555);
        // Local-only write visible over DRP.
        lb_we = 1'b1; lb_addr = 8'h40; lb_wdata = 16'h7777;
        tick();
        lb_we = 1'b0;
        drp_xact(1'b0, 10'h040, 16'h0000, 1'b0, 8'h00, 16'h0000, rd, ae, lat, bc);
        chk("lb_only do", 32'(rd), 32'h00007777);

        // Reset while in WAIT drops the transaction and clears the bank.
        bus.drp_en = 1'b1; bus.drp_we = 1'b0; bus.drp_addr = 10'h0FF;
        tick();
        bus.drp_en = 1'b0;
        tick();
        chk("wait busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst rdy", 32'(bus.drp_rdy), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst prot_err", 32'(prot_err), 32'd0);
        chk("rst lb_rdata", 32'(lb_rdata), 32'd0);
        tick(); tick();
        rst = 1'b0;
        rdy_n = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.drp_rdy) rdy_n++;
        end
        chk("rst no_rdy", 32'(rdy_n), 32'd0);
        drp_xact(1'b0, 10'h0FF, 16'h0000, 1'b0, 8'h00, 16'h0000, rd, ae, lat, bc);
        chk("rst clear_0FF", 32'(rd), 32'd0);
        chk("rst latency", 32'(lat), 32'(LAT));
        drp_xact(1'b0, 10'h012, 16'h0000, 1'b0, 8'h00, 16'h0000, rd, ae, lat, bc);
        chk("rst clear_012", 32'(rd), 32'd0);
        lb_addr = 8'h20;
        tick();
        chk("rst clear_lb", 32'(lb_rdata), 32'd0);

        // Read-only region behaviour with a fabric-owned value.
        lb_we = 1'b1; lb_addr = 8'hC5; lb_wdata = 16'h1357;
        tick();
        lb_we = 1'b0;
        drp_xact(1'b1, 10'h0C5, 16'hBEEF, 1'b0, 8'h00, 16'h0000, rd, ae, lat, bc);
        chk("ro write_latency", 32'(lat), 32'(LAT));
        chk("ro write_aerr", 32'(ae), 32'd0);
        drp_xact(1'b0, 10'h0C5, 16'h0000, 1'b0, 8'h00, 16'h0000, rd, ae, lat, bc);
        chk("ro read_do", 32'(rd), MASKED ? 32'h00001357 : 32'h0000BEEF);
        chk("ro read_aerr", 32'(ae), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
